fb_display_ctrl: RTL and testbench

//  Parametrised, double-buffered framebuffer read/write controller between the VGA timing gen and an external

---
 rtl/fb_pkg.sv | 14 +
 rtl/fb_scan_addr_gen.sv | 59 +++++
 rtl/fb_display_ctrl.sv | 111 +++++++++++
 tb/tb_fb_display_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and defaults for the double-buffered framebuffer display controller.
package fb_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned DEF_IMG_W = 195;
    localparam int unsigned DEF_IMG_H = 146;
    localparam int unsigned DEF_PIX_W = 16;

    typedef enum logic {
        IDLE,
        PENDING
    } swap_state_t;

endpackage

// File: rtl/fb_scan_addr_gen.sv
// Scan-out address generator: window test, power-of-2 downscale of screen coords,
// row*IMG_W+col. Two register stages (S1 coords, S2 RAM address).
module fb_scan_addr_gen
    import fb_pkg::*;
#(
    parameter int unsigned IMG_W      = DEF_IMG_W,
    parameter int unsigned IMG_H      = DEF_IMG_H,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned X_OFF      = 0,
    parameter int unsigned Y_OFF      = 0,
    parameter int unsigned BUF_AW     = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               front_sel,
    output logic [BUF_AW:0]    ram_addr_b,
    output logic               active_s2
);

    localparam int unsigned WIN_W = IMG_W << SCALE_LOG2;
    localparam int unsigned WIN_H = IMG_H << SCALE_LOG2;

    logic               active_c;
    logic [COORD_W-1:0] col_c;
    logic [COORD_W-1:0] row_c;
    logic               s1_active;
    logic [COORD_W-1:0] s1_col;
    logic [COORD_W-1:0] s1_row;
    logic [BUF_AW-1:0]  offset_c;

    // Subtraction wraps when left of / above the window; the >= terms mask that case.
    always_comb begin
        active_c = (32'(x) >= X_OFF) && (32'(y) >= Y_OFF) &&
                   ((32'(x) - X_OFF) < WIN_W) && ((32'(y) - Y_OFF) < WIN_H);
        col_c    = COORD_W'((32'(x) - X_OFF) >> SCALE_LOG2);
        row_c    = COORD_W'((32'(y) - Y_OFF) >> SCALE_LOG2);
    end

    assign offset_c = BUF_AW'(s1_row) * BUF_AW'(IMG_W) + BUF_AW'(s1_col);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_active  <= 1'b0;
            s1_col     <= '0;
            s1_row     <= '0;
            ram_addr_b <= '0;
            active_s2  <= 1'b0;
        end else begin
            s1_active  <= active_c;
            s1_col     <= col_c;
            s1_row     <= row_c;
            ram_addr_b <= {front_sel, s1_active ? offset_c : '0};
            active_s2  <= s1_active;
        end
    end

endmodule

// File: rtl/fb_display_ctrl.sv
// Double-buffered framebuffer controller: CPU port to back buffer, scaled scan-out
// from front buffer, vblank-synchronous swap. Optional macro FB_BORDER_EN adds BORDER_COLOR.
module fb_display_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned IMG_W      = DEF_IMG_W,
    parameter int unsigned IMG_H      = DEF_IMG_H,
    parameter int unsigned PIX_W      = DEF_PIX_W,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned X_OFF      = 0,
    parameter int unsigned Y_OFF      = 0,
    parameter int unsigned BUF_AW     = 15
`ifdef FB_BORDER_EN
    ,
    parameter logic [PIX_W-1:0] BORDER_COLOR = '0
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               i_vblank,
    input  logic [BUF_AW-1:0]  i_addr_a,
    input  logic [PIX_W-1:0]   i_data_a,
    input  logic               i_we_a,
    output logic [PIX_W-1:0]   o_data_a,
    input  logic               i_swap_req,
    output logic               o_swap_pending,
    output logic               o_front_sel,
    output logic [BUF_AW:0]    ram_addr_a,
    output logic [PIX_W-1:0]   ram_din_a,
    output logic               ram_we_a,
    input  logic [PIX_W-1:0]   ram_dout_a,
    output logic [BUF_AW:0]    ram_addr_b,
    input  logic [PIX_W-1:0]   ram_dout_b,
    output logic [PIX_W-1:0]   o_data_b,
    output logic               o_active_b
);

`ifdef FB_BORDER_EN
    localparam logic [PIX_W-1:0] OUTSIDE_PIX = BORDER_COLOR;
`else
    localparam logic [PIX_W-1:0] OUTSIDE_PIX = '0;
`endif

    swap_state_t state;
    swap_state_t state_nx;
    logic        front_nx;
    logic        active_s2;
    logic        active_s3;

    fb_scan_addr_gen #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .SCALE_LOG2(SCALE_LOG2),
        .X_OFF     (X_OFF),
        .Y_OFF     (Y_OFF),
        .BUF_AW    (BUF_AW)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .front_sel (o_front_sel),
        .ram_addr_b(ram_addr_b),
        .active_s2 (active_s2)
    );

    // CPU port always addresses the back buffer as seen this cycle.
    assign ram_addr_a     = {~o_front_sel, i_addr_a};
    assign ram_din_a      = i_data_a;
    assign ram_we_a       = i_we_a;
    assign o_data_a       = ram_dout_a;
    assign o_swap_pending = (state == PENDING);

    always_comb begin
        state_nx = state;
        front_nx = o_front_sel;
        unique case (state)
            IDLE: begin
                if (i_swap_req) begin
                    if (i_vblank) front_nx = ~o_front_sel;
                    else          state_nx = PENDING;
                end
            end
            PENDING: begin
                if (i_vblank) begin
                    front_nx = ~o_front_sel;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            o_front_sel <= 1'b0;
            active_s3   <= 1'b0;
            o_data_b    <= '0;
            o_active_b  <= 1'b0;
        end else begin
            state       <= state_nx;
            o_front_sel <= front_nx;
            active_s3   <= active_s2;
            o_data_b    <= active_s3 ? ram_dout_b : OUTSIDE_PIX;
            o_active_b  <= active_s3;
        end
    end

endmodule

// File: tb/tb_fb_display_ctrl.sv
// Directed self-checking bench for fb_display_ctrl (default and offset window instances).
module tb_fb_display_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        i_vblank, i_swap_req, i_we_a;
    logic [14:0] i_addr_a;
    logic [15:0] i_data_a, ram_dout_a;

    logic [15:0] o_data_a, ram_din_a, o_data_b, ram_dout_b;
    logic [15:0] ram_addr_a, ram_addr_b;
    logic        o_swap_pending, o_front_sel, ram_we_a, o_active_b;

    logic [15:0] o2_data_a, o2_ram_din_a, o2_data_b, ram2_dout_b;
    logic [15:0] o2_ram_addr_a, o2_ram_addr_b;
    logic        o2_swap_pending, o2_front_sel, o2_ram_we_a, o2_active_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] pix(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Port B RAM models, 1-cycle read latency
    always @(posedge clk) begin
        ram_dout_b  <= pix(ram_addr_b);
        ram2_dout_b <= pix(o2_ram_addr_b);
    end

    fb_display_ctrl dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .i_vblank(i_vblank),
        .i_addr_a(i_addr_a), .i_data_a(i_data_a), .i_we_a(i_we_a), .o_data_a(o_data_a),
        .i_swap_req(i_swap_req), .o_swap_pending(o_swap_pending), .o_front_sel(o_front_sel),
        .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a), .ram_we_a(ram_we_a),
        .ram_dout_a(ram_dout_a), .ram_addr_b(ram_addr_b), .ram_dout_b(ram_dout_b),
        .o_data_b(o_data_b), .o_active_b(o_active_b)
    );

    fb_display_ctrl #(.X_OFF(10), .Y_OFF(5)) dut_off (
        .clk(clk), .reset(reset), .x(x), .y(y), .i_vblank(i_vblank),
        .i_addr_a(i_addr_a), .i_data_a(i_data_a), .i_we_a(i_we_a), .o_data_a(o2_data_a),
        .i_swap_req(i_swap_req), .o_swap_pending(o2_swap_pending), .o_front_sel(o2_front_sel),
        .ram_addr_a(o2_ram_addr_a), .ram_din_a(o2_ram_din_a), .ram_we_a(o2_ram_we_a),
        .ram_dout_a(ram_dout_a), .ram_addr_b(o2_ram_addr_b), .ram_dout_b(ram2_dout_b),
        .o_data_b(o2_data_b), .o_active_b(o2_active_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [9:0]  sx [6] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd5, 10'd389};
    logic [9:0]  sy [6] = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd3, 10'd291};
    logic [15:0] sa [6] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd197, 16'd28469};

    initial begin
        reset = 1'b1; x = '0; y = '0; i_vblank = 1'b0; i_swap_req = 1'b0;
        i_we_a = 1'b0; i_addr_a = '0; i_data_a = '0; ram_dout_a = '0;
        cyc(2);
        chk("rst_data_b", o_data_b, 0);
        chk("rst_active_b", o_active_b, 0);
        chk("rst_addr_b", ram_addr_b, 0);
        chk("rst_pending", o_swap_pending, 0);
        chk("rst_front", o_front_sel, 0);
        reset = 1'b0;

        // streamed scan: address at edge2, pixel at edge4
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin x = sx[i]; y = sy[i]; end
            else begin x = '0; y = '0; end
            cyc(1);
            if (i >= 1 && i <= 6) chk($sformatf("stream_addr%0d", i - 1), ram_addr_b, sa[i-1]);
            if (i >= 3 && i <= 8) begin
                chk($sformatf("stream_data%0d", i - 3), o_data_b, pix(sa[i-3]));
                chk($sformatf("stream_act%0d", i - 3), o_active_b, 1);
            end
        end

        // outside the window
        x = 10'd390; y = 10'd0; cyc(4);
        chk("out_x_act", o_active_b, 0);
        chk("out_x_data", o_data_b, 0);
        chk("out_x_addr", ram_addr_b, 0);
        x = 10'd0; y = 10'd292; cyc(4);
        chk("out_y_act", o_active_b, 0);
        chk("out_y_data", o_data_b, 0);

        // CPU port
        x = '0; y = '0;
        i_addr_a = 15'h0010; i_data_a = 16'h1234; i_we_a = 1'b1; ram_dout_a = 16'hBEEF;
        #1;
        chk("cpu_addr_f0", ram_addr_a, 16'h8010);
        chk("cpu_din", ram_din_a, 16'h1234);
        chk("cpu_we", ram_we_a, 1);
        chk("cpu_dout", o_data_a, 16'hBEEF);

        // swap request, repeated request, then vblank 20 cycles later
        i_swap_req = 1'b1; cyc(1); i_swap_req = 1'b0;
        chk("swap_pend1", o_swap_pending, 1);
        chk("swap_front0", o_front_sel, 0);
        cyc(9);
        i_swap_req = 1'b1; cyc(1); i_swap_req = 1'b0;
        cyc(10);
        chk("swap_pend_hold", o_swap_pending, 1);
        i_vblank = 1'b1; #1;
        chk("cpu_addr_swapcyc", ram_addr_a, 16'h8010);
        cyc(1); i_vblank = 1'b0;
        chk("swap_pend0", o_swap_pending, 0);
        chk("swap_front1", o_front_sel, 1);
        chk("cpu_addr_f1", ram_addr_a, 16'h0010);
        i_we_a = 1'b0;
        cyc(2);
        chk("swap_addr_msb", ram_addr_b, 16'h8000);
        cyc(2);
        chk("swap_data", o_data_b, pix(16'h8000));

        // vblank alone in IDLE does nothing
        i_vblank = 1'b1; cyc(1); i_vblank = 1'b0;
        chk("vbl_idle_front", o_front_sel, 1);
        chk("vbl_idle_pend", o_swap_pending, 0);

        // simultaneous request and vblank swap at once
        i_swap_req = 1'b1; i_vblank = 1'b1; cyc(1);
        i_swap_req = 1'b0; i_vblank = 1'b0;
        chk("imm_front", o_front_sel, 0);
        chk("imm_pend", o_swap_pending, 0);
        cyc(1);
        chk("imm_pend2", o_swap_pending, 0);

        // reset mid-scan with a pending swap
        i_swap_req = 1'b1; cyc(1); i_swap_req = 1'b0;
        x = 10'd5; y = 10'd3; cyc(4);
        chk("pre_rst_act", o_active_b, 1);
        reset = 1'b1; #1;
        chk("mid_rst_data", o_data_b, 0);
        chk("mid_rst_act", o_active_b, 0);
        chk("mid_rst_addr", ram_addr_b, 0);
        chk("mid_rst_pend", o_swap_pending, 0);
        chk("mid_rst_front", o_front_sel, 0);
        cyc(1); reset = 1'b0;
        x = 10'd2; y = 10'd0; cyc(2);
        chk("post_rst_addr", ram_addr_b, 1);
        cyc(2);
        chk("post_rst_data", o_data_b, pix(16'd1));
        chk("post_rst_act", o_active_b, 1);

        // offset window X_OFF=10, Y_OFF=5
        x = 10'd12; y = 10'd6; cyc(2);
        chk("off_addr", o2_ram_addr_b, 1);
        cyc(2);
        chk("off_data", o2_data_b, pix(16'd1));
        chk("off_act", o2_active_b, 1);
        x = 10'd9; y = 10'd5; cyc(4);
        chk("off_left_act", o2_active_b, 0);
        chk("off_left_data", o2_data_b, 0);
        chk("off_left_addr", o2_ram_addr_b, 0);
        x = 10'd10; y = 10'd4; cyc(4);
        chk("off_top_act", o2_active_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
